// File: rtl/axi4lite_slave_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register-file slave and its bench.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // True when addr falls inside [base, base + span). The first term guards
  // the subtraction so an address below base cannot wrap into range.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi4lite_slave_regfile_if.sv
// AXI4-Lite bus bundle; the slave modport is what the register file sees.
interface axi4lite_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_slave_regfile_regbank.sv
// Register storage: one byte-strobed write port, one combinational read port.
module axi4lite_regbank #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                    i_clk,
  input  logic                    i_srst,
  input  logic                    i_we,
  input  logic [IDX_WIDTH-1:0]    i_widx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_WIDTH-1:0]    i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_merged;

  // Each lane takes the new byte when strobed, otherwise keeps the stored byte.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = i_wstrb[gi] ? i_wdata[gi*8 +: 8]
                                               : r_mem[i_widx][gi*8 +: 8];
    end
  endgenerate

  // Storage update: clear everything on reset, else write the merged word.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_widx] <= w_merged;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register file with independent write and read engines.
module axi4lite_slave_regfile
  import axi4lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic                  ACLK,
  input logic                  ARESET,
  axi4lite_slave_regfile_if.slave s_axi
);
  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  localparam int          BL         = $clog2(STRB_WIDTH);
  localparam int          IDX_WIDTH  = $clog2(NUM_REGS);
  localparam logic [63:0] SPAN       = 64'(NUM_REGS * STRB_WIDTH);

  // Write engine state
  wstate_t                 r_wstate, w_wstate_next;
  logic                    r_aw_held, w_aw_held_next;
  logic                    r_w_held, w_w_held_next;
  logic [ADDR_WIDTH-1:0]   r_awaddr, w_awaddr_next;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
  logic [STRB_WIDTH-1:0]   r_wstrb, w_wstrb_next;
  logic                    r_awready, w_awready_next;
  logic                    r_wready, w_wready_next;
  logic                    r_bvalid, w_bvalid_next;
  resp_t                   r_bresp, w_bresp_next;
  logic                    w_we;

  // Read engine state
  rstate_t                 r_rstate, w_rstate_next;
  logic                    r_arready, w_arready_next;
  logic                    r_rvalid, w_rvalid_next;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_next;
  resp_t                   r_rresp, w_rresp_next;

  // Decode
  logic                    w_aw_hs, w_w_hs, w_ar_hs;
  logic [ADDR_WIDTH-1:0]   w_wr_off, w_rd_off;
  logic [IDX_WIDTH-1:0]    w_wr_idx, w_rd_idx;
  logic                    w_wr_in_range, w_rd_in_range;
  logic [DATA_WIDTH-1:0]   w_bank_rdata;

  assign w_aw_hs = s_axi.AWVALID && r_awready;
  assign w_w_hs  = s_axi.WVALID && r_wready;
  assign w_ar_hs = s_axi.ARVALID && r_arready;

  // Writes decode the held address; reads decode ARADDR as it is accepted.
  // Shifting out the low BL bits makes unaligned addresses act aligned.
  assign w_wr_off      = r_awaddr - BASE_ADDR;
  assign w_rd_off      = s_axi.ARADDR - BASE_ADDR;
  assign w_wr_idx      = IDX_WIDTH'(w_wr_off >> BL);
  assign w_rd_idx      = IDX_WIDTH'(w_rd_off >> BL);
  assign w_wr_in_range = addr_in_range(64'(r_awaddr), 64'(BASE_ADDR), SPAN);
  assign w_rd_in_range = addr_in_range(64'(s_axi.ARADDR), 64'(BASE_ADDR), SPAN);

  axi4lite_regbank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_regbank (
    .i_clk  (ACLK),
    .i_srst (ARESET),
    .i_we   (w_we),
    .i_widx (w_wr_idx),
    .i_wdata(r_wdata),
    .i_wstrb(r_wstrb),
    .i_ridx (w_rd_idx),
    .o_rdata(w_bank_rdata)
  );

  // Write FSM next state: collect AW and W in any order, execute, then respond.
  always_comb begin
    w_wstate_next  = r_wstate;
    w_aw_held_next = r_aw_held;
    w_w_held_next  = r_w_held;
    w_awaddr_next  = r_awaddr;
    w_wdata_next   = r_wdata;
    w_wstrb_next   = r_wstrb;
    w_bvalid_next  = r_bvalid;
    w_bresp_next   = r_bresp;
    w_we           = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_aw_held_next = 1'b1;
          w_awaddr_next  = s_axi.AWADDR;
        end
        if (w_w_hs) begin
          w_w_held_next = 1'b1;
          w_wdata_next  = s_axi.WDATA;
          w_wstrb_next  = s_axi.WSTRB;
        end
        if (r_aw_held && r_w_held) begin
          w_wstate_next = W_EXEC;
        end
      end
      W_EXEC: begin
        w_we           = w_wr_in_range;
        w_bvalid_next  = 1'b1;
        w_bresp_next   = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        w_aw_held_next = 1'b0;
        w_w_held_next  = 1'b0;
        w_wstate_next  = W_RESP;
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          w_bvalid_next = 1'b0;
          w_wstate_next = W_IDLE;
        end
      end
      default: begin
        w_wstate_next = W_IDLE;
      end
    endcase
    // Readies are registered off the next state so they drop right after a handshake.
    w_awready_next = (w_wstate_next == W_IDLE) && !w_aw_held_next;
    w_wready_next  = (w_wstate_next == W_IDLE) && !w_w_held_next;
  end

  // Write engine registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_next;
      r_aw_held <= w_aw_held_next;
      r_w_held  <= w_w_held_next;
      r_awaddr  <= w_awaddr_next;
      r_wdata   <= w_wdata_next;
      r_wstrb   <= w_wstrb_next;
      r_awready <= w_awready_next;
      r_wready  <= w_wready_next;
      r_bvalid  <= w_bvalid_next;
      r_bresp   <= w_bresp_next;
    end
  end

  // Read FSM next state: capture data on AR, hold it until RREADY.
  // The bank read sees pre-update contents, so a same-cycle write gives old data.
  always_comb begin
    w_rstate_next = r_rstate;
    w_rvalid_next = r_rvalid;
    w_rdata_next  = r_rdata;
    w_rresp_next  = r_rresp;
    if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        w_rdata_next  = w_rd_in_range ? w_bank_rdata : '0;
        w_rresp_next  = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        w_rvalid_next = 1'b1;
        w_rstate_next = R_DATA;
      end
    end else begin
      if (s_axi.RREADY) begin
        w_rvalid_next = 1'b0;
        w_rstate_next = R_IDLE;
      end
    end
    w_arready_next = (w_rstate_next == R_IDLE);
  end

  // Read engine registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_next;
      r_arready <= w_arready_next;
      r_rvalid  <= w_rvalid_next;
      r_rdata   <= w_rdata_next;
      r_rresp   <= w_rresp_next;
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Self-checking bench: directed scenarios plus random traffic against a register model.
module tb_axi4lite_slave_regfile;
  import axi4lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4lite_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4lite_slave_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .BASE_ADDR (32'h0)
  ) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .s_axi (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [NR];

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkr(input string tag, input logic [1:0] obs, input resp_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%s", tag, obs, exp.name());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-addressed window of NR words starting at address 0.
  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output resp_t exp);
    int idx;
    if (a < NR * 4) begin
      idx = int'(a / 4);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      exp = RESP_OKAY;
    end else begin
      exp = RESP_SLVERR;
    end
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output resp_t exp);
    if (a < NR * 4) begin
      d   = model[int'(a / 4)];
      exp = RESP_OKAY;
    end else begin
      d   = 32'h0;
      exp = RESP_SLVERR;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input string tag);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0, lat = 0;
    resp_t exp;
    m_write(addr, data, strb, exp);
    bus.AWADDR = addr;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    bus.BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.AWVALID = !aw_done && (cyc >= aw_dly);
      bus.WVALID  = !w_done && (cyc >= w_dly);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      step();
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    checkb({tag, "_accepted"}, aw_done && w_done, 1'b1);
    while (!bus.BVALID && lat < 20) begin
      step();
      lat++;
    end
    checkb({tag, "_bvalid"}, bus.BVALID, 1'b1);
    checkr({tag, "_bresp"}, bus.BRESP, exp);
    if (aw_dly == w_dly) checkw({tag, "_b_latency"}, lat, 32'd2);
    step();
    checkb({tag, "_bvalid_drop"}, bus.BVALID, 1'b0);
    $display("WR %-12s addr=0x%02h data=0x%08h strb=%b awd=%0d wd=%0d resp=%s",
             tag, addr, data, strb, aw_dly, w_dly, exp.name());
  endtask

  task automatic axi_read(input logic [31:0] addr, input string tag);
    logic [31:0] expd;
    resp_t expr;
    int cyc = 0;
    m_read(addr, expd, expr);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b1;
    while (!bus.ARREADY && cyc < 20) begin
      step();
      cyc++;
    end
    checkb({tag, "_arready"}, bus.ARREADY, 1'b1);
    step();
    bus.ARVALID = 1'b0;
    checkb({tag, "_rvalid"}, bus.RVALID, 1'b1);
    checkw({tag, "_rdata"}, bus.RDATA, expd);
    checkr({tag, "_rresp"}, bus.RRESP, expr);
    step();
    checkb({tag, "_rvalid_drop"}, bus.RVALID, 1'b0);
    $display("RD %-12s addr=0x%02h exp=0x%08h got=0x%08h resp=%s",
             tag, addr, expd, bus.RDATA, expr.name());
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NR; i++) axi_read(32'(i * 4), tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_val;
    resp_t       exp;
    int          lat;

    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    checkb("rst_awready", bus.AWREADY, 1'b0);
    checkb("rst_wready", bus.WREADY, 1'b0);
    checkb("rst_arready", bus.ARREADY, 1'b0);
    checkb("rst_bvalid", bus.BVALID, 1'b0);
    checkb("rst_rvalid", bus.RVALID, 1'b0);
    checkr("rst_bresp", bus.BRESP, RESP_OKAY);
    checkr("rst_rresp", bus.RRESP, RESP_OKAY);
    checkw("rst_rdata", bus.RDATA, 32'h0);
    rst = 1'b0;
    step();
    checkb("idle_awready", bus.AWREADY, 1'b1);
    checkb("idle_wready", bus.WREADY, 1'b1);
    checkb("idle_arready", bus.ARREADY, 1'b1);
    $display("RESET done");

    // Aligned write/read
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, "aligned");
    axi_read(32'h04, "aligned");

    // Byte strobes
    axi_write(32'h00, 32'h11223344, 4'hF, 0, 0, "strb_init");
    axi_write(32'h00, 32'hAABBCCDD, 4'b0101, 0, 0, "strb");
    axi_read(32'h00, "strb");
    checkw("strb_model", model[0], 32'h11BB33DD);
    axi_write(32'h00, 32'hFFFFFFFF, 4'h0, 0, 0, "strb_zero");
    axi_read(32'h00, "strb_zero");

    // Order independence
    axi_write(32'h08, 32'h0A0B0C0D, 4'hF, 3, 0, "w_first");
    axi_read(32'h08, "w_first");
    axi_write(32'h08, 32'h5A5A1234, 4'hF, 0, 3, "aw_first");
    axi_read(32'h08, "aw_first");

    // Out of range, boundary and unaligned decode
    axi_write(32'h20, 32'h87654321, 4'hF, 0, 0, "oor");
    axi_write(32'h1C, 32'h1C1C1C1C, 4'hF, 0, 0, "last_reg");
    read_all("after_oor");
    axi_read(32'h20, "oor");
    axi_read(32'h23, "oor_unal");
    axi_read(32'h05, "unaligned");

    // Concurrency: AR handshake on the W_EXEC edge, then BREADY held low
    m_read(32'h04, old_val, exp);
    checkb("conc_pre_awready", bus.AWREADY, 1'b1);
    checkb("conc_pre_arready", bus.ARREADY, 1'b1);
    bus.AWADDR = 32'h04; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.BREADY = 1'b0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    step();
    bus.ARADDR = 32'h04; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    checkb("conc_rvalid", bus.RVALID, 1'b1);
    checkw("conc_old_rdata", bus.RDATA, old_val);
    checkr("conc_rresp", bus.RRESP, RESP_OKAY);
    m_write(32'h04, 32'hCAFEF00D, 4'hF, exp);
    for (int i = 0; i < 5; i++) begin
      checkb("bp_bvalid", bus.BVALID, 1'b1);
      checkr("bp_bresp", bus.BRESP, exp);
      step();
    end
    checkb("conc_read_done", bus.RVALID, 1'b0);
    bus.BREADY = 1'b1;
    step();
    checkb("bp_bvalid_drop", bus.BVALID, 1'b0);
    $display("WR backpressure addr=0x04 data=0xcafef00d old=0x%08h resp=%s", old_val, exp.name());
    axi_read(32'h04, "after_bp");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      else
        axi_read(a, "rand");
    end
    read_all("rand_final");

    // Reset while the write engine waits in W_RESP
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h13579BDF; bus.WSTRB = 4'hF; bus.BREADY = 1'b0;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    lat = 0;
    while (!bus.BVALID && lat < 20) begin
      step();
      lat++;
    end
    checkb("mid_bvalid", bus.BVALID, 1'b1);
    rst = 1'b1;
    step();
    checkb("mid_rst_bvalid", bus.BVALID, 1'b0);
    checkb("mid_rst_awready", bus.AWREADY, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    $display("RESET mid-operation");
    step();
    read_all("post_rst");
    axi_write(32'h0C, 32'h2468ACE0, 4'hF, 1, 0, "post_rst");
    axi_read(32'h0C, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
